axis_rate_monitor: RTL and testbench

Parametrised AXI-Stream throughput monitor that snoops one stream at its handshake (valid & ready) without driving it. It accumulates total bytes, beats, packets and active cycles, and measures per-window byte counts with peak tracking. It replaces the ad-hoc rx byte/cycle counters in the top level and is instantiated per direction (tx_user, rx_user) on coreclk_out. Results feed ILA/VIO debug and the user logic.

---
 rtl/axis_rate_monitor_if.sv | 31 +++
 rtl/axis_rate_monitor.sv | 246 ++++++++++++++++++++++++
 tb/tb_axis_rate_monitor.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_rate_monitor_if.sv
// AXI-Stream handshake bundle observed by axis_rate_monitor.
// The monitor modport is receive-only so the monitor can never drive the stream.
interface axis_rate_monitor_if #(
    parameter int KEEP_WIDTH = 8
) ();
    logic                  tvalid;
    logic                  tready;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;

    modport master (
        output tvalid,
        output tkeep,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tkeep,
        input  tlast,
        output tready
    );

    modport monitor (
        input tvalid,
        input tready,
        input tkeep,
        input tlast
    );
endinterface

// File: rtl/axis_rate_monitor.sv
// axis_rate_monitor: passive AXI-Stream throughput monitor.
// Counts bytes/beats/packets/active cycles at the handshake and produces a
// per-window byte count with peak tracking. All counters saturate.
// Optional macro RATE_MON_KEEP_CHECK_EN adds a sticky non-contiguous tkeep flag;
// without it keep_err is tied low.
module axis_rate_monitor #(
    parameter int DATA_WIDTH    = 64,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int CNT_WIDTH     = 64,
    parameter int WIN_WIDTH     = 32,
    parameter int WINDOW_CYCLES = 156250000
) (
    input  logic                        s_aclk,
    input  logic                        s_areset,
    input  logic                        enable,
    input  logic                        clear,
    axis_rate_monitor_if.monitor        mon,
    output logic                        running,
    output logic [CNT_WIDTH-1:0]        total_bytes,
    output logic [CNT_WIDTH-1:0]        total_beats,
    output logic [CNT_WIDTH-1:0]        total_pkts,
    output logic [CNT_WIDTH-1:0]        active_cycles,
    output logic [WIN_WIDTH-1:0]        win_bytes,
    output logic                        win_valid,
    output logic [WIN_WIDTH-1:0]        peak_win_bytes,
    output logic                        overflow,
    output logic                        keep_err
);

    localparam int BB_W = $clog2(KEEP_WIDTH + 1);

    // Slots of the shared saturating counter bank.
    localparam int NCNT       = 4;
    localparam int CNT_BYTES  = 0;
    localparam int CNT_BEATS  = 1;
    localparam int CNT_PKTS   = 2;
    localparam int CNT_ACTIVE = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic            beat;
    logic [BB_W-1:0] beat_bytes;
    logic            count_cycle;
    logic            count_beat;

    logic [NCNT-1:0][CNT_WIDTH-1:0] cnt_reg;
    logic [NCNT-1:0][CNT_WIDTH-1:0] cnt_next;
    logic [NCNT-1:0][CNT_WIDTH-1:0] cnt_inc;
    logic [NCNT-1:0]                cnt_en;
    logic [NCNT-1:0]                cnt_sat;

    logic [WIN_WIDTH-1:0] win_cnt_reg;
    logic [WIN_WIDTH-1:0] acc_reg;
    logic [WIN_WIDTH:0]   acc_sum;
    logic [WIN_WIDTH-1:0] acc_total;
    logic                 acc_sat;
    logic                 win_term;

    logic [WIN_WIDTH-1:0] win_bytes_reg;
    logic [WIN_WIDTH-1:0] peak_reg;
    logic                 win_valid_reg;
    logic                 overflow_reg;

    assign beat = mon.tvalid & mon.tready;

    // Number of bytes carried by this cycle's beat (popcount of tkeep).
    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            beat_bytes = beat_bytes + BB_W'(mon.tkeep[i]);
        end
    end

    // FSM register.
    always_ff @(posedge s_aclk or posedge s_areset) begin
        if (s_areset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state and the per-cycle "this cycle counts" decision.
    always_comb begin
        state_next  = state_reg;
        count_cycle = 1'b0;
        unique case (state_reg)
            IDLE: begin
                // Measurement starts on the first accepted beat, which counts.
                if (enable && beat) begin
                    state_next  = RUN;
                    count_cycle = 1'b1;
                end
            end
            RUN: begin
                // The cycle in which enable drops is not counted.
                if (enable) begin
                    count_cycle = 1'b1;
                end else begin
                    state_next = PAUSED;
                end
            end
            PAUSED: begin
                // Resuming cycle is already counted.
                if (enable) begin
                    state_next  = RUN;
                    count_cycle = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (clear) begin
            state_next  = IDLE;
            count_cycle = 1'b0;
        end
    end

    assign count_beat = count_cycle & beat;

    // Increment amount and enable per counter slot.
    assign cnt_inc[CNT_BYTES]  = CNT_WIDTH'(beat_bytes);
    assign cnt_inc[CNT_BEATS]  = CNT_WIDTH'(1);
    assign cnt_inc[CNT_PKTS]   = CNT_WIDTH'(1);
    assign cnt_inc[CNT_ACTIVE] = CNT_WIDTH'(1);
    assign cnt_en[CNT_BYTES]   = count_beat;
    assign cnt_en[CNT_BEATS]   = count_beat;
    assign cnt_en[CNT_PKTS]    = count_beat & mon.tlast;
    assign cnt_en[CNT_ACTIVE]  = count_cycle;

    // Saturating adders: a carry out clamps the counter to all-ones and flags it.
    genvar gi;
    generate
        for (gi = 0; gi < NCNT; gi++) begin : g_cnt
            logic [CNT_WIDTH:0] sum;
            assign sum          = {1'b0, cnt_reg[gi]} + {1'b0, cnt_inc[gi]};
            assign cnt_sat[gi]  = cnt_en[gi] & sum[CNT_WIDTH];
            assign cnt_next[gi] = !cnt_en[gi]      ? cnt_reg[gi] :
                                  sum[CNT_WIDTH]   ? {CNT_WIDTH{1'b1}} :
                                                     sum[CNT_WIDTH-1:0];
        end
    endgenerate

    // Window accumulator including this cycle's counted beat, saturating.
    assign acc_sum   = {1'b0, acc_reg} + (WIN_WIDTH + 1)'(count_beat ? beat_bytes : '0);
    assign acc_sat   = count_beat & acc_sum[WIN_WIDTH];
    assign acc_total = acc_sum[WIN_WIDTH] ? {WIN_WIDTH{1'b1}} : acc_sum[WIN_WIDTH-1:0];

    // Terminal cycle: the counted cycle that brings the window count to WINDOW_CYCLES.
    assign win_term = count_cycle && (win_cnt_reg == WIN_WIDTH'(WINDOW_CYCLES - 1));

    // Totals, active cycle count and sticky overflow.
    always_ff @(posedge s_aclk or posedge s_areset) begin
        if (s_areset) begin
            cnt_reg      <= '0;
            overflow_reg <= 1'b0;
        end else if (clear) begin
            cnt_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            if ((|cnt_sat) || acc_sat) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Window counter and accumulator; both restart after the terminal cycle.
    always_ff @(posedge s_aclk or posedge s_areset) begin
        if (s_areset) begin
            win_cnt_reg <= '0;
            acc_reg     <= '0;
        end else if (clear) begin
            win_cnt_reg <= '0;
            acc_reg     <= '0;
        end else if (win_term) begin
            win_cnt_reg <= '0;
            acc_reg     <= '0;
        end else if (count_cycle) begin
            win_cnt_reg <= win_cnt_reg + WIN_WIDTH'(1);
            acc_reg     <= acc_total;
        end
    end

    // Completed-window result, one-cycle valid pulse and peak tracking.
    always_ff @(posedge s_aclk or posedge s_areset) begin
        if (s_areset) begin
            win_bytes_reg <= '0;
            peak_reg      <= '0;
            win_valid_reg <= 1'b0;
        end else if (clear) begin
            win_bytes_reg <= '0;
            peak_reg      <= '0;
            win_valid_reg <= 1'b0;
        end else begin
            win_valid_reg <= win_term;
            if (win_term) begin
                win_bytes_reg <= acc_total;
                if (acc_total > peak_reg) begin
                    peak_reg <= acc_total;
                end
            end
        end
    end

`ifdef RATE_MON_KEEP_CHECK_EN
    // Legal keep is 2^n-1 with n >= 1: bit 0 set and no hole above the low run.
    logic keep_ok;
    logic keep_err_reg;
    assign keep_ok = mon.tkeep[0] &&
                     ((mon.tkeep & (mon.tkeep + KEEP_WIDTH'(1))) == '0);

    // Sticky flag for counted beats carrying an illegal keep pattern.
    always_ff @(posedge s_aclk or posedge s_areset) begin
        if (s_areset) begin
            keep_err_reg <= 1'b0;
        end else if (clear) begin
            keep_err_reg <= 1'b0;
        end else if (count_beat && !keep_ok) begin
            keep_err_reg <= 1'b1;
        end
    end
    assign keep_err = keep_err_reg;
`else
    assign keep_err = 1'b0;
`endif

    assign running        = (state_reg == RUN);
    assign total_bytes    = cnt_reg[CNT_BYTES];
    assign total_beats    = cnt_reg[CNT_BEATS];
    assign total_pkts     = cnt_reg[CNT_PKTS];
    assign active_cycles  = cnt_reg[CNT_ACTIVE];
    assign win_bytes      = win_bytes_reg;
    assign win_valid      = win_valid_reg;
    assign peak_win_bytes = peak_reg;
    assign overflow       = overflow_reg;

endmodule

// File: tb/tb_axis_rate_monitor.sv
// Directed bench for axis_rate_monitor: a per-cycle vector table for the basic
// counting/pause behaviour, then hand-written window, pause, clear, keep and
// reset sequences. A second instance with CNT_WIDTH=8 exercises saturation.
module tb_axis_rate_monitor;
    localparam int KW      = 8;
    localparam int WIN_CYC = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          enable;
    logic          clear;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic [KW-1:0] tkeep;

    axis_rate_monitor_if #(.KEEP_WIDTH(KW)) mon_if  ();
    axis_rate_monitor_if #(.KEEP_WIDTH(KW)) mon8_if ();

    assign mon_if.tvalid  = tvalid;
    assign mon_if.tready  = tready;
    assign mon_if.tkeep   = tkeep;
    assign mon_if.tlast   = tlast;
    assign mon8_if.tvalid = tvalid;
    assign mon8_if.tready = tready;
    assign mon8_if.tkeep  = tkeep;
    assign mon8_if.tlast  = tlast;

    logic        running, win_valid, overflow, keep_err;
    logic [63:0] total_bytes, total_beats, total_pkts, active_cycles;
    logic [31:0] win_bytes, peak_win_bytes;

    logic        running8, win_valid8, overflow8, keep_err8;
    logic [7:0]  total_bytes8, total_beats8, total_pkts8, active_cycles8;
    logic [31:0] win_bytes8, peak_win_bytes8;

    axis_rate_monitor #(
        .DATA_WIDTH(64), .CNT_WIDTH(64), .WIN_WIDTH(32), .WINDOW_CYCLES(WIN_CYC)
    ) dut (
        .s_aclk(clk), .s_areset(rst), .enable(enable), .clear(clear), .mon(mon_if),
        .running(running), .total_bytes(total_bytes), .total_beats(total_beats),
        .total_pkts(total_pkts), .active_cycles(active_cycles), .win_bytes(win_bytes),
        .win_valid(win_valid), .peak_win_bytes(peak_win_bytes), .overflow(overflow),
        .keep_err(keep_err)
    );

    axis_rate_monitor #(
        .DATA_WIDTH(64), .CNT_WIDTH(8), .WIN_WIDTH(32), .WINDOW_CYCLES(WIN_CYC)
    ) dut8 (
        .s_aclk(clk), .s_areset(rst), .enable(enable), .clear(clear), .mon(mon8_if),
        .running(running8), .total_bytes(total_bytes8), .total_beats(total_beats8),
        .total_pkts(total_pkts8), .active_cycles(active_cycles8), .win_bytes(win_bytes8),
        .win_valid(win_valid8), .peak_win_bytes(peak_win_bytes8), .overflow(overflow8),
        .keep_err(keep_err8)
    );

`ifdef RATE_MON_KEEP_CHECK_EN
    localparam logic KEEP_ERR_EXP = 1'b1;
`else
    localparam logic KEEP_ERR_EXP = 1'b0;
`endif

    typedef struct {
        logic        en;
        logic        vld;
        logic        rdy;
        logic [7:0]  keep;
        logic        last;
        logic        exp_run;
        logic [63:0] exp_bytes;
        logic [63:0] exp_beats;
        logic [63:0] exp_pkts;
        logic [63:0] exp_active;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic vld, input logic rdy,
                         input logic [7:0] keep, input logic last, input logic clr);
        enable = en;
        tvalid = vld;
        tready = rdy;
        tkeep  = keep;
        tlast  = last;
        clear  = clr;
    endtask

    // Advance one clock; inputs were set after the previous edge, outputs sampled 1 ns after this one.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".running"},  64'(running), 64'd0);
        chk({tag, ".bytes"},    total_bytes, 64'd0);
        chk({tag, ".beats"},    total_beats, 64'd0);
        chk({tag, ".pkts"},     total_pkts, 64'd0);
        chk({tag, ".active"},   active_cycles, 64'd0);
        chk({tag, ".win_bytes"}, 64'(win_bytes), 64'd0);
        chk({tag, ".win_valid"}, 64'(win_valid), 64'd0);
        chk({tag, ".peak"},     64'(peak_win_bytes), 64'd0);
        chk({tag, ".overflow"}, 64'(overflow), 64'd0);
        chk({tag, ".keep_err"}, 64'(keep_err), 64'd0);
    endtask

    initial begin
        // ---- Vector table: basic counting, ignored beats, pause and resume ----
        vq.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0});
        vq.push_back('{1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0});
        vq.push_back('{1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0});
        for (int k = 1; k <= 10; k++) begin
            vq.push_back('{1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1,
                           64'(8 * k), 64'(k), 64'd0, 64'(k)});
        end
        vq.push_back('{1'b1, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, 64'd84, 64'd11, 64'd1, 64'd11});
        vq.push_back('{1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 64'd84, 64'd11, 64'd1, 64'd12});
        vq.push_back('{1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 64'd84, 64'd11, 64'd1, 64'd12});
        vq.push_back('{1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 64'd84, 64'd11, 64'd1, 64'd12});
        vq.push_back('{1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 64'd92, 64'd12, 64'd2, 64'd13});

        // ---- Reset state ----
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) cyc();
        chk_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].en, vq[i].vld, vq[i].rdy, vq[i].keep, vq[i].last, 1'b0);
            cyc();
            chk($sformatf("vec%0d.running", i), 64'(running), 64'(vq[i].exp_run));
            chk($sformatf("vec%0d.bytes", i),   total_bytes,   vq[i].exp_bytes);
            chk($sformatf("vec%0d.beats", i),   total_beats,   vq[i].exp_beats);
            chk($sformatf("vec%0d.pkts", i),    total_pkts,    vq[i].exp_pkts);
            chk($sformatf("vec%0d.active", i),  active_cycles, vq[i].exp_active);
            chk($sformatf("vec%0d.win_valid", i), 64'(win_valid), 64'd0);
            $display("vec %0d: running=%0d bytes=%0d beats=%0d pkts=%0d active=%0d",
                     i, running, total_bytes, total_beats, total_pkts, active_cycles);
        end

        // ---- Clear, then 40 continuous full beats: windows at 16 and 32 ----
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc();
        chk_zero("clear1");
        for (int c = 1; c <= 40; c++) begin
            drive(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
            cyc();
            chk($sformatf("win40.c%0d.win_valid", c), 64'(win_valid),
                64'((c == 16) || (c == 32)));
            if (c == 16 || c == 32) begin
                chk($sformatf("win40.c%0d.win_bytes", c), 64'(win_bytes), 64'd128);
            end
            $display("win40 cycle %0d: win_valid=%0d win_bytes=%0d", c, win_valid, win_bytes);
        end
        chk("win40.peak",     64'(peak_win_bytes), 64'd128);
        chk("win40.active",   active_cycles, 64'd40);
        chk("win40.bytes",    total_bytes, 64'd320);
        chk("win40.overflow", 64'(overflow), 64'd0);
        chk("sat8.bytes",     64'(total_bytes8), 64'd255);
        chk("sat8.overflow",  64'(overflow8), 64'd1);
        chk("sat8.beats",     64'(total_beats8), 64'd40);
        chk("sat8.active",    64'(active_cycles8), 64'd40);

        // ---- Pause: 5 half beats, 7 paused cycles with beats held, resume ----
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc();
        chk("pause.clr.overflow8", 64'(overflow8), 64'd0);
        for (int c = 1; c <= 5; c++) begin
            drive(1'b1, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0);
            cyc();
        end
        chk("pause.pre.bytes", total_bytes, 64'd20);
        for (int c = 1; c <= 7; c++) begin
            drive(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
            cyc();
            chk($sformatf("pause.p%0d.bytes", c),  total_bytes, 64'd20);
            chk($sformatf("pause.p%0d.beats", c),  total_beats, 64'd5);
            chk($sformatf("pause.p%0d.active", c), active_cycles, 64'd5);
            chk($sformatf("pause.p%0d.running", c), 64'(running), 64'd0);
            chk($sformatf("pause.p%0d.win_valid", c), 64'(win_valid), 64'd0);
            $display("pause cycle %0d: running=%0d beats=%0d", c, running, total_beats);
        end
        for (int r = 1; r <= 12; r++) begin
            drive(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
            cyc();
            chk($sformatf("resume.r%0d.win_valid", r), 64'(win_valid), 64'(r == 11));
            if (r == 11) begin
                chk("resume.win_bytes", 64'(win_bytes), 64'd108);
                chk("resume.peak",      64'(peak_win_bytes), 64'd108);
            end
            $display("resume cycle %0d: win_valid=%0d win_bytes=%0d", r, win_valid, win_bytes);
        end
        chk("resume.active", active_cycles, 64'd17);
        chk("resume.pkts",   total_pkts, 64'd0);

        // ---- Clear coincident with a beat on the window terminal cycle ----
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc();
        for (int c = 1; c <= 15; c++) begin
            drive(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
            cyc();
        end
        chk("cterm.pre.active", active_cycles, 64'd15);
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
        cyc();
        chk_zero("cterm");
        drive(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
        cyc();
        chk("cterm.idle.running", 64'(running), 64'd0);
        chk("cterm.idle.active",  active_cycles, 64'd0);
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        cyc();
        chk("cterm.restart.active",  active_cycles, 64'd1);
        chk("cterm.restart.bytes",   total_bytes, 64'd8);
        chk("cterm.restart.running", 64'(running), 64'd1);
        $display("clear-on-terminal: restart active=%0d bytes=%0d", active_cycles, total_bytes);

        // ---- Non-contiguous keep ----
        chk("keep.pre.keep_err", 64'(keep_err), 64'd0);
        drive(1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0);
        cyc();
        chk("keep.bytes",    total_bytes, 64'd10);
        chk("keep.keep_err", 64'(keep_err), 64'(KEEP_ERR_EXP));
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        cyc();
        chk("keep.sticky",   64'(keep_err), 64'(KEEP_ERR_EXP));
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc();
        chk("keep.clr.keep_err", 64'(keep_err), 64'd0);
        $display("keep check: keep_err cleared=%0d", keep_err);

        // ---- Asynchronous reset mid-window ----
        for (int c = 1; c <= 5; c++) begin
            drive(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
            cyc();
        end
        chk("areset.pre.beats", total_beats, 64'd5);
        rst = 1'b1;
        #1;
        chk_zero("areset");
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc();
        rst = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            cyc();
            chk($sformatf("areset.idle%0d.win_valid", c), 64'(win_valid), 64'd0);
        end
        drive(1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);
        cyc();
        chk("areset.restart.active", active_cycles, 64'd1);
        chk("areset.restart.bytes",  total_bytes, 64'd1);
        chk("areset.restart.pkts",   total_pkts, 64'd1);
        $display("async reset: restart active=%0d bytes=%0d", active_cycles, total_bytes);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
